ahb_addr_decoder: RTL and testbench
===================================

Name: ahb_addr_decoder

Overview:
- Address-phase decoder and default slave for the three-slave system bus.
- Decodes HADDR into per-slave HSEL lines.
- Registers the decoded slave index into the data phase as SEL, which steers the downstream response multiplexer.
- Contains a built-in default slave that returns a two-cycle ERROR response for active transfers to unmapped addresses.

Parameters:
- S1_BASE, 32'h0000_0000, base address of slave 1
- S1_MASK, 32'hF000_0000, address bits compared for slave 1
- S2_BASE, 32'h1000_0000, base address of slave 2
- S2_MASK, 32'hF000_0000, address bits compared for slave 2
- S3_BASE, 32'h2000_0000, base address of slave 3
- S3_MASK, 32'hF000_0000, address bits compared for slave 3

Ports:
- CLK  input  1  bus clock
- RST  input  1  reset; synchronous, active-high
- HADDR  input  32  address-phase address
- HTRANS  input  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HREADY  input  1  global ready; an address phase is accepted when HREADY=1
- HSEL_1, HSEL_2, HSEL_3  output  1 each  address-phase slave selects (combinational)
- SEL  output  2  registered data-phase select: 00 none/default, 01 slave1, 10 slave2, 11 slave3
- HREADYOUT_DEF  output  1  default-slave ready
- HRESP_DEF  output  2  default-slave response: OKAY=00, ERROR=01

Behaviour:
- Decode is combinational.
  - Slave n hits when (HADDR & Sn_MASK) == (Sn_BASE & Sn_MASK).
  - On overlapping hits, priority is slave1 > slave2 > slave3; exactly one HSEL is high on any hit.
  - HSEL_n follows the address decode regardless of HTRANS.
  - No hit: all HSEL_n = 0 (unmapped).
- SEL register:
  - Loads the encoded decode result on every rising CLK where HREADY=1.
  - Unmapped addresses load 00.
  - Holds its value while HREADY=0, so a stalled data phase keeps its slave.
- Default slave FSM, states IDLE, ERR1, ERR2:
  - IDLE:
    - Outputs HREADYOUT_DEF=1, HRESP_DEF=00.
    - Goes to ERR1 when HREADY=1, HTRANS[1]=1 (NONSEQ/SEQ) and the address is unmapped.
    - IDLE or BUSY transfers to unmapped addresses stay in IDLE and receive a zero-wait OKAY.
  - ERR1:
    - Outputs HREADYOUT_DEF=0, HRESP_DEF=01.
    - Always goes to ERR2 next cycle.
  - ERR2:
    - Outputs HREADYOUT_DEF=1, HRESP_DEF=01.
    - The next address phase is sampled in this cycle, since the global HREADY is high.
    - A new active unmapped transfer goes to ERR1 (back-to-back errors).
    - Anything else goes to IDLE.
  - Outputs are registered state decodes, so there is no combinational path from HADDR to HRESP_DEF or HREADYOUT_DEF.
- Latency:
  - SEL and the default-slave response appear one cycle after the accepted address phase.
  - An ERROR response takes exactly two data-phase cycles.
- Reset:
  - RST=1 at a rising edge forces SEL=00, FSM=IDLE, HREADYOUT_DEF=1 and HRESP_DEF=00, overriding any in-flight error.
  - HSEL_n stay combinational through reset.
- Simultaneous events:
  - If RST and an accepted unmapped transfer occur in the same cycle, reset wins; no error is issued.
  - HREADY=0 in IDLE has no effect on the FSM.
  - Entry to ERR1 occurs only from IDLE or ERR2.

Decomposition:
- Shared package bus_pkg holds:
  - HTRANS codes (IDLE, BUSY, NONSEQ, SEQ).
  - HRESP codes (OKAY, ERROR, RETRY, SPLIT).
  - SEL codes (SEL_NONE=00, SEL_S1=01, SEL_S2=10, SEL_S3=11).
  - The default address map constants.
- One sub-module, ahb_default_slave, containing the three-state FSM. Its inputs are CLK, RST, HREADY, HTRANS and a hit_none flag; its outputs are HREADYOUT_DEF and HRESP_DEF.
- Decode logic and the SEL register stay in the top level.

Test Plan:
- Reset: assert RST for 2 cycles with NONSEQ to 32'h1000_0004 and HREADY=1 -> SEL=00, HREADYOUT_DEF=1, HRESP_DEF=00. The first cycle after release loads SEL=10.
- Mapped decode: NONSEQ to 32'h0000_0010, 32'h1000_0000, 32'h2FFF_FFFC on consecutive HREADY=1 cycles -> HSEL_1, HSEL_2, HSEL_3 pulse in turn; SEL reads 01, 10, 11 one cycle later each; HRESP_DEF stays 00.
- Wait-state hold: NONSEQ to 32'h2000_0000 accepted, then HREADY=0 for 3 cycles with a new HADDR=32'h0000_0000 -> SEL holds 11 for all 3 cycles and loads 01 only when HREADY returns to 1.
- Unmapped error: NONSEQ to 32'h8000_0000 -> next cycle SEL=00, HREADYOUT_DEF=0, HRESP_DEF=01; following cycle HREADYOUT_DEF=1, HRESP_DEF=01; then IDLE with OKAY.
- Back-to-back and IDLE-unmapped: during ERR2 present SEQ to 32'h9000_0000 -> ERR1 again. Separately, HTRANS=IDLE to 32'h8000_0000 -> HREADYOUT_DEF=1, HRESP_DEF=00 with no ERR1.
- Reset mid-error: assert RST in the ERR1 cycle -> next cycle FSM=IDLE, HREADYOUT_DEF=1, HRESP_DEF=00, SEL=00.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared system-bus encodings (HTRANS, HRESP, data-phase select) and the default
// three-slave address map.
package bus_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01,
      HRESP_RETRY = 2'b10,
      HRESP_SPLIT = 2'b11
   } hresp_t;

   typedef enum logic [1:0] {
      SEL_NONE = 2'b00,
      SEL_S1   = 2'b01,
      SEL_S2   = 2'b10,
      SEL_S3   = 2'b11
   } sel_t;

   localparam logic [31:0] MAP_S1_BASE = 32'h0000_0000;
   localparam logic [31:0] MAP_S1_MASK = 32'hF000_0000;
   localparam logic [31:0] MAP_S2_BASE = 32'h1000_0000;
   localparam logic [31:0] MAP_S2_MASK = 32'hF000_0000;
   localparam logic [31:0] MAP_S3_BASE = 32'h2000_0000;
   localparam logic [31:0] MAP_S3_MASK = 32'hF000_0000;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers active transfers to unmapped addresses with a two-cycle
// ERROR response; outputs are registered alongside the state.
module ahb_default_slave
   import bus_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       HREADY,
   input  logic [1:0] HTRANS,
   input  logic       hit_none,
   output logic       HREADYOUT_DEF,
   output logic [1:0] HRESP_DEF
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ERR1 = 2'b01,
      ST_ERR2 = 2'b10
   } state_t;

   state_t state_p1;
   logic   err_start;
   logic   unused_htrans0;

   // Only NONSEQ/SEQ (HTRANS[1]) count as active; IDLE/BUSY get a zero-wait OKAY.
   assign err_start      = HREADY & HTRANS[1] & hit_none;
   assign unused_htrans0 = HTRANS[0];

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_p1      <= ST_IDLE;
         HREADYOUT_DEF <= 1'b1;
         HRESP_DEF     <= HRESP_OKAY;
      end else begin
         case (state_p1)
            ST_ERR1: begin
               state_p1      <= ST_ERR2;
               HREADYOUT_DEF <= 1'b1;
               HRESP_DEF     <= HRESP_ERROR;
            end
            default: begin
               if (err_start) begin
                  state_p1      <= ST_ERR1;
                  HREADYOUT_DEF <= 1'b0;
                  HRESP_DEF     <= HRESP_ERROR;
               end else begin
                  state_p1      <= ST_IDLE;
                  HREADYOUT_DEF <= 1'b1;
                  HRESP_DEF     <= HRESP_OKAY;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/ahb_addr_decoder.sv
// Address-phase decoder for the three-slave bus: combinational HSEL lines, a
// registered data-phase SEL, and the built-in default slave.
module ahb_addr_decoder
   import bus_pkg::*;
#(
   parameter logic [31:0] S1_BASE = MAP_S1_BASE,
   parameter logic [31:0] S1_MASK = MAP_S1_MASK,
   parameter logic [31:0] S2_BASE = MAP_S2_BASE,
   parameter logic [31:0] S2_MASK = MAP_S2_MASK,
   parameter logic [31:0] S3_BASE = MAP_S3_BASE,
   parameter logic [31:0] S3_MASK = MAP_S3_MASK
)
(
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HREADY,
   output logic        HSEL_1,
   output logic        HSEL_2,
   output logic        HSEL_3,
   output logic [1:0]  SEL,
   output logic        HREADYOUT_DEF,
   output logic [1:0]  HRESP_DEF
);

   logic       hit1, hit2, hit3, hit_none;
   sel_t       sel_nxt;
   logic [1:0] sel_p1;

   assign hit1     = (HADDR & S1_MASK) == (S1_BASE & S1_MASK);
   assign hit2     = (HADDR & S2_MASK) == (S2_BASE & S2_MASK);
   assign hit3     = (HADDR & S3_MASK) == (S3_BASE & S3_MASK);
   assign hit_none = ~(hit1 | hit2 | hit3);

   // Overlapping regions resolve slave1 > slave2 > slave3.
   assign HSEL_1 = hit1;
   assign HSEL_2 = hit2 & ~hit1;
   assign HSEL_3 = hit3 & ~hit1 & ~hit2;

   always_comb begin
      sel_nxt = SEL_NONE;
      if (hit3) sel_nxt = SEL_S3;
      if (hit2) sel_nxt = SEL_S2;
      if (hit1) sel_nxt = SEL_S1;
   end

   // Data-phase boundary: SEL holds through wait states so a stalled slave keeps the mux.
   always_ff @(posedge CLK) begin
      if (RST)
         sel_p1 <= SEL_NONE;
      else if (HREADY)
         sel_p1 <= sel_nxt;
   end

   assign SEL = sel_p1;

   ahb_default_slave u_default_slave (
      .CLK           (CLK),
      .RST           (RST),
      .HREADY        (HREADY),
      .HTRANS        (HTRANS),
      .hit_none      (hit_none),
      .HREADYOUT_DEF (HREADYOUT_DEF),
      .HRESP_DEF     (HRESP_DEF)
   );

endmodule

// File: tb/tb_ahb_addr_decoder.sv
// Self-checking bench for ahb_addr_decoder: directed test-plan steps followed by
// randomized traffic compared against a range-based reference model.
module tb_ahb_addr_decoder;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HREADY;
   logic        HSEL_1, HSEL_2, HSEL_3;
   logic [1:0]  SEL;
   logic        HREADYOUT_DEF;
   logic [1:0]  HRESP_DEF;

   int checks = 0;
   int passed = 0;

   // Reference model state: selected slave of the data phase, and the number of
   // ERROR data-phase cycles still to be presented (2 = first, 1 = second).
   int m_sel = 0;
   int m_err = 0;

   ahb_addr_decoder dut (
      .CLK           (CLK),
      .RST           (RST),
      .HADDR         (HADDR),
      .HTRANS        (HTRANS),
      .HREADY        (HREADY),
      .HSEL_1        (HSEL_1),
      .HSEL_2        (HSEL_2),
      .HSEL_3        (HSEL_3),
      .SEL           (SEL),
      .HREADYOUT_DEF (HREADYOUT_DEF),
      .HRESP_DEF     (HRESP_DEF)
   );

   always #5 CLK = ~CLK;

   // Address map as plain ranges: 256 MB regions starting at 0.
   function automatic int slave_of(input logic [31:0] a);
      if (a < 32'h1000_0000) return 1;
      if (a < 32'h2000_0000) return 2;
      if (a < 32'h3000_0000) return 3;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // One bus cycle: drive inputs, check decode, clock, check registered outputs.
   task automatic cycle(input logic [31:0] a, input logic [1:0] t, input logic r, input logic rs);
      int s;
      HADDR = a; HTRANS = t; HREADY = r; RST = rs;
      #1;
      s = slave_of(a);
      chk("hsel", {29'd0, HSEL_3, HSEL_2, HSEL_1}, (s == 0) ? 32'd0 : (32'd1 << (s - 1)));
      @(posedge CLK);
      if (rs) begin
         m_sel = 0;
         m_err = 0;
      end else begin
         if (r) m_sel = s;
         if (m_err == 2)                    m_err = 1;
         else if (r && t[1] && s == 0)      m_err = 2;
         else                               m_err = 0;
      end
      #1;
      chk("sel",      {30'd0, SEL},           m_sel);
      chk("hreadyout", {31'd0, HREADYOUT_DEF}, (m_err == 2) ? 32'd0 : 32'd1);
      chk("hresp",    {30'd0, HRESP_DEF},     (m_err != 0) ? 32'd1 : 32'd0);
      @(negedge CLK);
   endtask

   initial begin
      RST = 1'b1; HADDR = '0; HTRANS = 2'b00; HREADY = 1'b1;
      @(negedge CLK);

      // Reset with a live NONSEQ, then release.
      cycle(32'h1000_0004, 2'b10, 1'b1, 1'b1);
      cycle(32'h1000_0004, 2'b10, 1'b1, 1'b1);
      chk("rst_sel", {30'd0, SEL}, 32'd0);
      chk("rst_resp", {30'd0, HRESP_DEF}, 32'd0);
      cycle(32'h1000_0004, 2'b10, 1'b1, 1'b0);
      chk("release_sel", {30'd0, SEL}, 32'd2);

      // Mapped decode on consecutive accepted phases.
      cycle(32'h0000_0010, 2'b10, 1'b1, 1'b0);
      chk("map_s1", {30'd0, SEL}, 32'd1);
      cycle(32'h1000_0000, 2'b10, 1'b1, 1'b0);
      chk("map_s2", {30'd0, SEL}, 32'd2);
      cycle(32'h2FFF_FFFC, 2'b10, 1'b1, 1'b0);
      chk("map_s3", {30'd0, SEL}, 32'd3);

      // Wait-state hold.
      cycle(32'h2000_0000, 2'b10, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(32'h0000_0000, 2'b10, 1'b0, 1'b0);
         chk("hold_sel", {30'd0, SEL}, 32'd3);
      end
      cycle(32'h0000_0000, 2'b10, 1'b1, 1'b0);
      chk("hold_release", {30'd0, SEL}, 32'd1);

      // Unmapped error: two ERROR cycles, then OKAY.
      cycle(32'h8000_0000, 2'b10, 1'b1, 1'b0);
      chk("err1_ready", {31'd0, HREADYOUT_DEF}, 32'd0);
      chk("err1_resp", {30'd0, HRESP_DEF}, 32'd1);
      cycle(32'h8000_0000, 2'b00, 1'b0, 1'b0);
      chk("err2_ready", {31'd0, HREADYOUT_DEF}, 32'd1);
      chk("err2_resp", {30'd0, HRESP_DEF}, 32'd1);
      cycle(32'h0000_0000, 2'b00, 1'b1, 1'b0);
      chk("after_err", {30'd0, HRESP_DEF}, 32'd0);

      // Back-to-back errors via SEQ in ERR2.
      cycle(32'h8000_0000, 2'b10, 1'b1, 1'b0);
      cycle(32'h0000_0000, 2'b00, 1'b0, 1'b0);
      cycle(32'h9000_0000, 2'b11, 1'b1, 1'b0);
      chk("b2b_ready", {31'd0, HREADYOUT_DEF}, 32'd0);
      cycle(32'h0000_0000, 2'b00, 1'b0, 1'b0);
      cycle(32'h0000_0000, 2'b00, 1'b1, 1'b0);

      // IDLE and BUSY to unmapped get OKAY.
      cycle(32'h8000_0000, 2'b00, 1'b1, 1'b0);
      chk("idle_unmapped", {29'd0, HREADYOUT_DEF, HRESP_DEF}, 32'h4);
      cycle(32'h8000_0000, 2'b01, 1'b1, 1'b0);
      chk("busy_unmapped", {29'd0, HREADYOUT_DEF, HRESP_DEF}, 32'h4);

      // Reset during ERR1, and reset together with an accepted unmapped transfer.
      cycle(32'hC000_0000, 2'b10, 1'b1, 1'b0);
      cycle(32'h1000_0000, 2'b10, 1'b1, 1'b1);
      chk("rst_mid_err", {28'd0, HREADYOUT_DEF, HRESP_DEF, SEL[0]}, 32'h8);
      cycle(32'hC000_0000, 2'b10, 1'b1, 1'b1);
      chk("rst_wins", {29'd0, HREADYOUT_DEF, HRESP_DEF}, 32'h4);

      // Randomized traffic against the model.
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         a = {4'($urandom_range(0, 7)), 28'($urandom)};
         cycle(a, 2'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within budget");
      $fatal(1, "timeout");
   end

endmodule
